// File: rtl/exp_stream_ctrl.sv
// Valid/ready stream wrapper around the bfloat16 exponential core: buffers operands
// in a small FIFO, issues one at a time, holds each result for downstream, then releases the core.
`timescale 1ns/1ps

module exp_stream_ctrl #(
  parameter int DW      = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  // upstream operand stream
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  // downstream result stream
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  input  logic          out_ready_i,
  // exponential core handshake
  output logic          core_valid_o,
  output logic [DW-1:0] core_data_o,
  output logic          core_padv_o,
  input  logic          core_ready_i,
  input  logic          core_valid_i,
  input  logic [DW-1:0] core_data_i,
  // status
  output logic          err_o,
  output logic [15:0]   done_cnt_o,
  output logic          busy_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] QNAN = DW'(16'h7FC0);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD,
    ADV
  } state_t;

  state_t state_q, state_d;

  // Operand FIFO
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty, push, pop;

  // Datapath registers
  logic [DW-1:0] op_q, res_q;
  logic [WW-1:0] wd_q, wd_inc;
  logic          timeout_hit;
  logic          err_q;
  logic [15:0]   done_cnt_q;

  // Control strobes from the FSM
  logic capture_res, capture_to, deliver;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = in_valid_i && !full;

  assign wd_inc      = wd_q + WW'(1);
  assign timeout_hit = (wd_inc == WW'(TIMEOUT));

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
    state_d      = state_q;
    pop          = 1'b0;
    core_valid_o = 1'b0;
    core_padv_o  = 1'b0;
    out_valid_o  = 1'b0;
    capture_res  = 1'b0;
    capture_to   = 1'b0;
    deliver      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Head must already be registered in the FIFO; nothing falls through.
        if (!empty && core_ready_i) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        core_valid_o = 1'b1;
        state_d      = WAIT;
      end
      WAIT: begin
        // A result arriving on the timeout cycle takes priority over the watchdog.
        if (core_valid_i) begin
          capture_res = 1'b1;
          state_d     = HOLD;
        end else if (timeout_hit) begin
          capture_to = 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          deliver = 1'b1;
          state_d = ADV;
        end
      end
      ADV: begin
        core_padv_o = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      op_q       <= '0;
      res_q      <= '0;
      wd_q       <= '0;
      err_q      <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        op_q     <= mem[rd_ptr_q];
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase

      if (state_q == ISSUE)     wd_q <= '0;
      else if (state_q == WAIT) wd_q <= wd_inc;

      if (capture_res) begin
        res_q <= core_data_i;
      end else if (capture_to) begin
        res_q <= QNAN;
        err_q <= 1'b1;
      end

      if (deliver) done_cnt_q <= done_cnt_q + 16'd1;
    end
  end

  // NOTE: FIFO storage has no reset; the reset pointers and count make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data_i;
  end

  assign in_ready_o  = !full;
  assign out_data_o  = res_q;
  assign core_data_o = op_q;
  assign err_o       = err_q;
  assign done_cnt_o  = done_cnt_q;
  assign busy_o      = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_exp_stream_ctrl.sv
// Directed bench for exp_stream_ctrl with a latency-3 core model and an in-order result scoreboard.
`timescale 1ns/1ps

module tb_exp_stream_ctrl;

  localparam int DW  = 16;
  localparam int LAT = 3;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready_o;
  logic          out_valid_o;
  logic [DW-1:0] out_data_o;
  logic          out_ready;
  logic          core_valid_o;
  logic [DW-1:0] core_data_o;
  logic          core_padv_o;
  logic          core_rdy;
  logic          core_vld;
  logic [DW-1:0] core_res;
  logic          err_o;
  logic [15:0]   done_cnt_o;
  logic          busy_o;

  exp_stream_ctrl #(.DW(DW), .DEPTH(4), .TIMEOUT(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_data_i   (in_data),
    .in_ready_o  (in_ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready),
    .core_valid_o(core_valid_o),
    .core_data_o (core_data_o),
    .core_padv_o (core_padv_o),
    .core_ready_i(core_rdy),
    .core_valid_i(core_vld),
    .core_data_i (core_res),
    .err_o       (err_o),
    .done_cnt_o  (done_cnt_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_issue = 0;
  int n_padv = 0;
  int cv_cyc = 0;
  int ov_cyc = 0;
  bit ov_prev = 1'b0;
  bit m_dead = 1'b0;
  logic [DW-1:0] sb[$];

  function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] x);
    core_fn = (x == 16'h3F80) ? 16'h402E : ({x[7:0], x[15:8]} ^ 16'h0041);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [DW-1:0] x, input logic [DW-1:0] exp);
    in_valid = 1'b1;
    in_data  = x;
    tick();
    in_valid = 1'b0;
    sb.push_back(exp);
  endtask

  task automatic wait_done(input logic [15:0] target, input int budget, input string tag);
    int n = 0;
    while (done_cnt_o !== target && n < budget) begin
      tick();
      n++;
    end
    check(tag, done_cnt_o, target);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      tick();
      n++;
    end
    check("idle", busy_o, 1'b0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: samples on valid&&ready, answers LAT edges later with a one-cycle valid.
  int m_cnt = 0;
  bit m_busy = 1'b0;
  logic [DW-1:0] m_op;
  always @(posedge clk) begin
    if (!rst) begin
      m_busy   <= 1'b0;
      core_vld <= 1'b0;
      core_res <= '0;
    end else begin
      core_vld <= 1'b0;
      if (core_valid_o && core_rdy) begin
        m_busy <= 1'b1;
        m_cnt  <= LAT;
        m_op   <= core_data_o;
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          if (!m_dead) begin
            core_vld <= 1'b1;
            core_res <= core_fn(m_op);
          end
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  // Output monitor and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (core_valid_o) begin
        n_issue++;
        cv_cyc = cyc;
      end
      if (core_padv_o) n_padv++;
      if (out_valid_o && !ov_prev) ov_cyc = cyc;
      if (out_valid_o && out_ready) begin
        if (sb.size() == 0) check("spurious_out", out_valid_o, 1'b0);
        else check("out_data", out_data_o, sb.pop_front());
      end
    end
    ov_prev = out_valid_o;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    int push_edge;
    int accepted;
    int drop_at;
    int iss_snap;
    int n;
    bit acc;
    logic [DW-1:0] snap;

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    core_rdy  = 1'b1;
    repeat (3) tick();

    // Reset state
    check("rst_in_ready", in_ready_o, 1'b1);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_core_valid", core_valid_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_done_cnt", done_cnt_o, 16'h0000);
    check("rst_busy", busy_o, 1'b0);
    rst = 1'b1;
    tick();

    // Single operation with exact cycle positions
    push_edge = cyc + 1;
    push_one(16'h3F80, 16'h402E);
    wait_done(16'd1, 60, "t1_done");
    repeat (2) tick();
    check("t1_issue_lat", cv_cyc - push_edge, 1);
    check("t1_out_lat", ov_cyc - push_edge, 6);
    check("t1_issue_cnt", n_issue, 1);
    check("t1_padv_cnt", n_padv, 1);
    wait_idle(20);

    // Back-to-back burst filling the FIFO
    accepted = 0;
    drop_at  = -1;
    for (int i = 0; i < 300 && accepted < 6; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h3C00 + 16'(accepted) * 16'h0123;
      if (!in_ready_o && drop_at < 0) drop_at = accepted;
      acc = in_ready_o;
      tick();
      if (acc) begin
        sb.push_back(core_fn(in_data));
        accepted++;
      end
    end
    in_valid = 1'b0;
    check("t2_full_at", drop_at, 5);
    wait_done(16'd7, 400, "t2_done");
    wait_idle(20);
    check("t2_sb_empty", sb.size(), 0);

    // Downstream stall in HOLD
    out_ready = 1'b0;
    push_one(16'h4100, core_fn(16'h4100));
    push_one(16'h4180, core_fn(16'h4180));
    n = 0;
    while (!out_valid_o && n < 40) begin
      tick();
      n++;
    end
    check("t3_hold_valid", out_valid_o, 1'b1);
    snap     = out_data_o;
    iss_snap = n_issue;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t3_stable_data", out_data_o, snap);
      check("t3_no_padv", core_padv_o, 1'b0);
    end
    check("t3_no_reissue", n_issue, iss_snap);
    check("t3_hold_data", snap, core_fn(16'h4100));
    out_ready = 1'b1;
    wait_done(16'd9, 200, "t3_done");
    wait_idle(20);

    // Watchdog: core never answers
    m_dead = 1'b1;
    push_one(16'h4000, 16'h7FC0);
    wait_done(16'd10, 200, "t4_done");
    check("t4_err", err_o, 1'b1);
    check("t4_timeout_lat", ov_cyc - cv_cyc, 65);
    wait_idle(20);
    m_dead = 1'b0;
    push_one(16'h3E00, core_fn(16'h3E00));
    wait_done(16'd11, 60, "t4_after_done");
    check("t4_err_sticky", err_o, 1'b1);
    wait_idle(20);

    // Reset while in WAIT with two entries queued
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'h5000 + 16'(i);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
    check("t5_in_ready", in_ready_o, 1'b1);
    check("t5_out_valid", out_valid_o, 1'b0);
    check("t5_out_data", out_data_o, 16'h0000);
    check("t5_core_valid", core_valid_o, 1'b0);
    check("t5_core_data", core_data_o, 16'h0000);
    check("t5_core_padv", core_padv_o, 1'b0);
    check("t5_err", err_o, 1'b0);
    check("t5_done_cnt", done_cnt_o, 16'h0000);
    check("t5_busy", busy_o, 1'b0);
    rst = 1'b1;
    iss_snap = n_issue;
    repeat (40) tick();
    check("t5_no_issue", n_issue, iss_snap);
    check("t5_done_still0", done_cnt_o, 16'h0000);
    check("t5_busy_after", busy_o, 1'b0);

    // Delivery counter wrap
    force dut.done_cnt_q = 16'hFFFF;
    tick();
    release dut.done_cnt_q;
    tick();
    check("t6_preload", done_cnt_o, 16'hFFFF);
    push_one(16'h3F00, core_fn(16'h3F00));
    wait_done(16'h0000, 60, "t6_wrap");
    wait_idle(20);
    check("t6_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
